// File: rtl/regfile_sb.sv
// Byte-enabled register file with a per-register busy scoreboard.
// Reads are combinational with same-cycle writeback bypass; register 0 can be hardwired to zero.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 1,
  localparam int ADDR_W    = $clog2(NUM_REGS),
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     rs1,
  input  logic [ADDR_W-1:0]     rs2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [BE_W-1:0]       byte_en,
  input  logic                  issue_valid,
  input  logic [ADDR_W-1:0]     issue_rd,
  output logic [ADDR_W:0]       busy_count
);

  localparam bit HARD_ZERO = (ZERO_REG != 0);
  localparam int CNT_W     = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]      busy_count_q, busy_count_d;

  logic [DATA_WIDTH-1:0] merged;
  logic                  wr_ok, iss_ok, cnt_inc, cnt_dec;

  // Strobes without backpressure: we and issue_valid are accepted on every edge outside reset.
  assign wr_ok  = we && !(HARD_ZERO && rd == '0);
  assign iss_ok = issue_valid && !(HARD_ZERO && issue_rd == '0);

  always_comb begin
    merged = regs_q[rd];
    for (int k = 0; k < BE_W; k++) begin
      if (byte_en[k]) merged[8*k +: 8] = write_data[8*k +: 8];
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[rd] = merged;
  end

  // The issue is applied after the writeback clear so a same-register collision ends busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[rd]       = 1'b0;
    if (iss_ok) busy_d[issue_rd] = 1'b1;
  end

  // Count tracks set/clear transitions of the busy bits, so it can never pass the number of usable registers.
  always_comb begin
    cnt_inc      = iss_ok && !busy_q[issue_rd];
    cnt_dec      = wr_ok && busy_q[rd] && !(iss_ok && issue_rd == rd);
    busy_count_d = busy_count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  always_comb begin
    read_data1 = (wr_ok && rs1 == rd) ? merged : regs_q[rs1];
    read_data2 = (wr_ok && rs2 == rd) ? merged : regs_q[rs2];
    if (reset || (HARD_ZERO && rs1 == '0)) read_data1 = '0;
    if (reset || (HARD_ZERO && rs2 == '0)) read_data2 = '0;
    busy1 = !reset && busy_q[rs1] && !(we && rd == rs1);
    busy2 = !reset && busy_q[rs2] && !(we && rd == rs2);
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, byte merge, zero register, scoreboard and async reset.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd, issue_rd;
  logic [31:0] read_data1, read_data2, write_data;
  logic        busy1, busy2, we, issue_valid;
  logic [3:0]  byte_en;
  logic [5:0]  busy_count;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .read_data1(read_data1), .read_data2(read_data2),
    .busy1(busy1), .busy2(busy2), .we(we), .rd(rd),
    .write_data(write_data), .byte_en(byte_en),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; issue_valid = 1'b0; byte_en = 4'h0; write_data = '0; rd = '0; issue_rd = '0;
  endtask

  initial begin
    reset = 1'b1; rs1 = '0; rs2 = '0;
    idle();
    #1;
    check("reset_rd1", read_data1, 32'h0);
    check("reset_cnt", {26'b0, busy_count}, 32'd0);
    tick();
    reset = 1'b0;

    // Full write with same-cycle bypass on port 2
    we = 1'b1; rd = 5'd5; write_data = 32'hDEADBEEF; byte_en = 4'hF; rs2 = 5'd5;
    #1;
    check("bypass_rd2", read_data2, 32'hDEADBEEF);
    tick();
    idle(); rs1 = 5'd5;
    #1;
    check("stored_rd1", read_data1, 32'hDEADBEEF);

    // Partial byte write
    we = 1'b1; rd = 5'd3; write_data = 32'h11223344; byte_en = 4'hF;
    tick();
    write_data = 32'hAABBCCDD; byte_en = 4'b0101; rs1 = 5'd3;
    #1;
    check("merge_bypass", read_data1, 32'h11BB33DD);
    tick();
    idle();
    #1;
    check("merge_stored", read_data1, 32'h11BB33DD);

    // Register 0 stays zero and never goes busy
    we = 1'b1; rd = 5'd0; write_data = 32'hFFFFFFFF; byte_en = 4'hF;
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    #1;
    check("zero_bypass", read_data1, 32'h0);
    tick();
    idle();
    #1;
    check("zero_read", read_data1, 32'h0);
    check("zero_busy", {31'b0, busy1}, 32'd0);
    check("zero_cnt", {26'b0, busy_count}, 32'd0);

    // Scoreboard counting
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_rd = 5'd9;
    tick();
    idle();
    check("cnt_two", {26'b0, busy_count}, 32'd2);
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle(); rs1 = 5'd7;
    #1;
    check("cnt_reissue", {26'b0, busy_count}, 32'd2);
    check("busy7_set", {31'b0, busy1}, 32'd1);
    we = 1'b1; rd = 5'd7; byte_en = 4'h0; write_data = 32'h55555555;
    #1;
    check("busy7_comb_clear", {31'b0, busy1}, 32'd0);
    tick();
    idle();
    #1;
    check("cnt_after_wb", {26'b0, busy_count}, 32'd1);
    check("be0_holds", read_data1, 32'h0);
    rs1 = 5'd9;
    #1;
    check("busy9_kept", {31'b0, busy1}, 32'd1);

    // Issue and writeback to the same busy register
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    idle();
    check("cnt_issue4", {26'b0, busy_count}, 32'd2);
    issue_valid = 1'b1; issue_rd = 5'd4;
    we = 1'b1; rd = 5'd4; write_data = 32'hCAFEF00D; byte_en = 4'hF;
    tick();
    idle(); rs1 = 5'd4;
    #1;
    check("coll_data", read_data1, 32'hCAFEF00D);
    check("coll_busy", {31'b0, busy1}, 32'd1);
    check("coll_cnt", {26'b0, busy_count}, 32'd2);

    // Mid-stream asynchronous reset
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    idle(); rs2 = 5'd9;
    #1;
    check("cnt_three", {26'b0, busy_count}, 32'd3);
    #1;
    reset = 1'b1;
    #1;
    check("rst_rd1", read_data1, 32'h0);
    check("rst_busy1", {31'b0, busy1}, 32'd0);
    check("rst_busy2", {31'b0, busy2}, 32'd0);
    check("rst_cnt", {26'b0, busy_count}, 32'd0);
    we = 1'b1; rd = 5'd6; write_data = 32'h12345678; byte_en = 4'hF;
    issue_valid = 1'b1; issue_rd = 5'd6; rs1 = 5'd6;
    #1;
    check("rst_bypass", read_data1, 32'h0);
    tick();
    idle();
    reset = 1'b0;
    #1;
    check("rst_wr_ignored", read_data1, 32'h0);
    check("rst_iss_ignored", {26'b0, busy_count}, 32'd0);
    rs2 = 5'd4;
    #1;
    check("rst_busy4_clear", {31'b0, busy2}, 32'd0);
    check("rst_reg4_clear", read_data2, 32'h0);
    we = 1'b1; rd = 5'd6; write_data = 32'h12345678; byte_en = 4'hF;
    tick();
    idle();
    #1;
    check("post_rst_write", read_data1, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NUM_REGS, default 32, register count; SHALL be a power of two, at least 2.
REQ-003 Parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero and 0 makes register 0 ordinary.
REQ-004 Local ADDR_W = $clog2(NUM_REGS) and BE_W = DATA_WIDTH/8 SHALL size the ports below.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port reset, input, 1, asynchronous, active-high reset.
REQ-007 Port rs1, input, ADDR_W, read address, port 1.
REQ-008 Port rs2, input, ADDR_W, read address, port 2.
REQ-009 Port read_data1, output, DATA_WIDTH, read data, port 1.
REQ-010 Port read_data2, output, DATA_WIDTH, read data, port 2.
REQ-011 Port busy1, output, 1, register rs1 has a pending write.
REQ-012 Port busy2, output, 1, register rs2 has a pending write.
REQ-013 Port we, input, 1, writeback strobe.
REQ-014 Port rd, input, ADDR_W, writeback address.
REQ-015 Port write_data, input, DATA_WIDTH, writeback data.
REQ-016 Port byte_en, input, BE_W, per-byte write enable; bit k covers bits [8k+7:8k].
REQ-017 Port issue_valid, input, 1, an instruction claims a destination register.
REQ-018 Port issue_rd, input, ADDR_W, claimed destination register.
REQ-019 Port busy_count, output, ADDR_W+1, number of registers currently busy.

Function
REQ-020 Storage SHALL be NUM_REGS x DATA_WIDTH flops.
REQ-021 Write: on a rising clk edge with we=1, each byte of regs[rd] whose byte_en bit is 1 SHALL take the matching write_data byte; other bytes SHALL hold.
REQ-022 Reads SHALL be combinational, with zero-cycle latency.
REQ-023 Write bypass: when we=1 and rsN==rd, read_dataN SHALL return the merged value (write_data bytes where byte_en=1, stored bytes otherwise) in the same cycle.
REQ-024 With ZERO_REG=1, writes to register 0 SHALL be ignored, read_dataN SHALL return 0 for rsN=0 (bypass included), and register 0 SHALL never become busy.
REQ-025 Scoreboard: one busy bit per register; issue_valid=1 SHALL set busy[issue_rd] at the next edge.
REQ-026 we=1 SHALL clear busy[rd] at the next edge, regardless of byte_en value.
REQ-027 If issue_valid=1 and we=1 target the same register in one cycle, busy SHALL end set; the issue is newer and wins.
REQ-028 Issuing to an already-busy register SHALL leave it busy (no count); a writeback to a non-busy register SHALL write data and leave busy clear.
REQ-029 busyN SHALL equal busy[rsN] AND NOT (we AND rd==rsN), so a same-cycle writeback de-asserts the stall combinationally.
REQ-030 busy_count SHALL be a registered count of set busy bits, updated at the edge where the busy bits change; net change per cycle is -1, 0 or +1.
REQ-031 busy_count SHALL never exceed NUM_REGS-ZERO_REG; it SHALL need no saturation logic by construction.

Reset
REQ-032 Asserting reset SHALL immediately clear all registers, all busy bits and busy_count, with no clock needed.
REQ-033 During reset, read_data1/2, busy1/2 and busy_count SHALL read 0; we and issue_valid SHALL be ignored.
REQ-034 Deassertion of reset SHALL be treated as synchronous to clk; the first write or issue SHALL take effect at the first edge after deassertion.
REQ-035 Reset asserted mid-operation SHALL abandon any pending write and clear every outstanding busy bit.

Verification
REQ-036 Reset, then we=1, rd=5, write_data=0xDEADBEEF, byte_en=4'hF; next cycle rs1=5 -> read_data1=0xDEADBEEF; same-cycle rs2=5 during the write -> read_data2=0xDEADBEEF via bypass.
REQ-037 regs[3]=0x11223344, then write 0xAABBCCDD with byte_en=4'b0101 -> regs[3]=0x11BB33DD.
REQ-038 ZERO_REG=1, write 0xFFFFFFFF to rd=0, and issue_rd=0 -> read_data1=0 at rs1=0, busy1=0, busy_count=0.
REQ-039 Issue to 7, then issue to 9 -> busy_count=2; issue to 7 again -> still 2; we to rd=7 with rs1=7 -> busy1=0 in the same cycle and busy_count=1 after the edge.
REQ-040 Same-cycle issue_rd=4 and we with rd=4 while reg 4 is busy -> reg 4 holds the new data, busy stays 1, busy_count unchanged.
REQ-041 Assert reset mid-stream with busy_count=3 -> outputs immediately 0 and all busy bits clear; the first post-reset write succeeds.
